// File: rtl/sram_avalon_arbiter_if.sv
// Avalon-MM command/response bundle shared by the arbiter's master-facing and SRAM-facing ports.
// The master modport is the side that issues commands; the slave modport is the side that answers them.
interface sram_avalon_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              write_n;
    logic              read_n;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, writedata, write_n, read_n,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, writedata, write_n, read_n,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sram_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SRAM port between the NPU DMA (m0) and the frame reader (m1).
// A stalled command stays locked to its master; read responses are steered back through an in-order ID FIFO.
module sram_avalon_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    sram_avalon_arbiter_if.slave         m0,
    sram_avalon_arbiter_if.slave         m1,
    sram_avalon_arbiter_if.master        s,
    output logic [$clog2(MAX_PENDING):0] rd_pending,
    output logic                         rsp_error
);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              id_mem [MAX_PENDING];

    logic [1:0]        req;
    logic [1:0]        wr;
    logic [1:0]        rd;
    logic [1:0]        elig;
    logic              rd_room;
    logic              pick;
    logic              pick_valid;
    logic              sel_valid;
    logic              mux_idx;
    logic              sel_wr;
    logic              sel_rd;
    logic              accept;
    logic              push;
    logic              pop;
    logic              pop_err;
    logic              head;
    logic [ADDR_W-1:0] mux_address;
    logic [DATA_W-1:0] mux_writedata;

    // Write wins when a master drives both strobes low, so its read is treated as absent.
    assign wr[0]   = !m0.write_n;
    assign wr[1]   = !m1.write_n;
    assign rd[0]   = m0.write_n && !m0.read_n;
    assign rd[1]   = m1.write_n && !m1.read_n;
    assign req     = wr | rd;
    assign rd_room = (count < CNT_W'(MAX_PENDING));
    assign elig    = wr | (rd & {2{rd_room}});

    always_comb begin
        // NOTE: every output gets a default up front so no path through this block infers a latch.
        pick       = 1'b0;
        pick_valid = 1'b0;
        if (state == ST_LOCKED) begin
            pick       = owner;
            pick_valid = req[owner];
        end else if (elig[0] && elig[1]) begin
            pick       = ~last_grant;
            pick_valid = 1'b1;
        end else if (elig[0]) begin
            pick       = 1'b0;
            pick_valid = 1'b1;
        end else if (elig[1]) begin
            pick       = 1'b1;
            pick_valid = 1'b1;
        end
    end

    // Nothing is granted while reset is held, even though the selection logic is combinational.
    assign sel_valid     = pick_valid && !RESET;
    assign mux_idx       = sel_valid ? pick : owner;
    assign mux_address   = mux_idx ? m1.address   : m0.address;
    assign mux_writedata = mux_idx ? m1.writedata : m0.writedata;
    assign sel_wr        = mux_idx ? wr[1] : wr[0];
    assign sel_rd        = mux_idx ? rd[1] : rd[0];

    assign s.address   = mux_address;
    assign s.writedata = mux_writedata;
    assign s.write_n   = !(sel_valid && sel_wr);
    assign s.read_n    = !(sel_valid && sel_rd);

    assign accept         = sel_valid && !s.waitrequest;
    assign m0.waitrequest = req[0] && !(accept && !mux_idx);
    assign m1.waitrequest = req[1] && !(accept &&  mux_idx);

    assign push    = accept && sel_rd;
    assign pop     = s.readdatavalid && (count != '0) && !RESET;
    assign pop_err = s.readdatavalid && (count == '0);
    assign head    = id_mem[rd_ptr];

    assign m0.readdatavalid = pop && !head;
    assign m1.readdatavalid = pop &&  head;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign rd_pending       = count;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_OPEN;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_error  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            if (accept)  last_grant <= mux_idx;
            if (pop_err) rsp_error  <= 1'b1;
            case (state)
                ST_OPEN: begin
                    if (sel_valid && s.waitrequest) begin
                        state <= ST_LOCKED;
                        owner <= mux_idx;
                    end
                end
                ST_LOCKED: begin
                    // A master that drops its stalled command releases the port.
                    if (accept || !req[owner]) state <= ST_OPEN;
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: ID storage has no reset; entries are only read between the reset-cleared pointers.
    always_ff @(posedge CLOCK) begin
        if (push) id_mem[wr_ptr] <= mux_idx;
    end
endmodule
